// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache controller for the MEM stage.
// A miss stalls the pipeline while the victim line is written back (if dirty) and
// the requested line is filled over a line-wide req/ack memory handshake.
//
// Memory handshake: mem_req_o is held high with mem_we_o/mem_addr_o/mem_wdata_o
// stable for the whole transaction; mem_ack_i is a one-cycle pulse that completes
// it (it may arrive in the very first request cycle). A fill's data is taken from
// mem_rdata_i in the ack cycle. Acks seen while no transaction is open are ignored.
module dcache_controller #(
   parameter int LINES  = 32,
   parameter int LINE_W = 256,
   parameter int TAG_W  = 22
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              cpu_req_i,
   input  logic              cpu_we_i,
   input  logic [31:0]       cpu_addr_i,
   input  logic [31:0]       cpu_wdata_i,
   output logic [31:0]       cpu_rdata_o,
   output logic              cpu_stall_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [31:0]       mem_addr_o,
   output logic [LINE_W-1:0] mem_wdata_o,
   input  logic [LINE_W-1:0] mem_rdata_i,
   input  logic              mem_ack_i
);

   localparam int IW = $clog2(LINES);
   localparam int LW = TAG_W + IW;   // line-number width (address bits 31:5)

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WRITEBACK = 2'd1,
      ALLOCATE  = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [LINES-1:0]    valid_q, valid_d;
   logic [LINES-1:0]    dirty_q, dirty_d;
   logic [LW-1:0]       miss_line_q, miss_line_d;
   logic                mem_req_q, mem_req_d;
   logic                mem_we_q, mem_we_d;
   logic [31:0]         mem_addr_q, mem_addr_d;
   logic [LINE_W-1:0]   mem_wdata_q, mem_wdata_d;

   // Tag and data storage carry no reset; valid bits guard them.
   logic [TAG_W-1:0]    tag_arr_q  [LINES];
   logic [LINE_W-1:0]   data_arr_q [LINES];

   logic [IW-1:0]       cpu_idx;
   logic [TAG_W-1:0]    cpu_tag;
   logic [2:0]          cpu_word;
   logic [IW-1:0]       miss_idx;
   logic [TAG_W-1:0]    miss_tag;
   logic                hit;
   logic                fill_en;
   logic                store_en;
   logic                addr_lsb_unused;

   assign cpu_idx         = cpu_addr_i[IW+4:5];
   assign cpu_tag         = cpu_addr_i[31:IW+5];
   assign cpu_word        = cpu_addr_i[4:2];
   assign addr_lsb_unused = |cpu_addr_i[1:0];

   // The missing line is latched so the fill completes even if the CPU drops its request.
   assign miss_idx = miss_line_q[IW-1:0];
   assign miss_tag = miss_line_q[LW-1:IW];

   assign hit         = cpu_req_i & valid_q[cpu_idx] & (tag_arr_q[cpu_idx] == cpu_tag);
   assign cpu_stall_o = cpu_req_i & ((state_q != IDLE) | ~hit);
   assign cpu_rdata_o = data_arr_q[cpu_idx][{cpu_word, 5'b0} +: 32];

   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;

   // Next-state logic: miss detection, write-back/fill sequencing and store-hit marking.
   always_comb begin
      state_d     = state_q;
      valid_d     = valid_q;
      dirty_d     = dirty_q;
      miss_line_d = miss_line_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      fill_en     = 1'b0;
      store_en    = 1'b0;

      case (state_q)
         IDLE: begin
            if (cpu_req_i && !hit) begin
               miss_line_d = cpu_addr_i[31:5];
               mem_req_d   = 1'b1;
               if (valid_q[cpu_idx] && dirty_q[cpu_idx]) begin
                  state_d     = WRITEBACK;
                  mem_we_d    = 1'b1;
                  mem_addr_d  = {tag_arr_q[cpu_idx], cpu_idx, 5'b0};
                  mem_wdata_d = data_arr_q[cpu_idx];
               end else begin
                  state_d    = ALLOCATE;
                  mem_we_d   = 1'b0;
                  mem_addr_d = {cpu_addr_i[31:5], 5'b0};
               end
            end else if (cpu_req_i && cpu_we_i) begin
               store_en         = 1'b1;
               dirty_d[cpu_idx] = 1'b1;
            end
         end
         WRITEBACK: begin
            // Request stays high; the fill starts the cycle after the write-back ack.
            if (mem_ack_i) begin
               state_d    = ALLOCATE;
               mem_we_d   = 1'b0;
               mem_addr_d = {miss_line_q, 5'b0};
            end
         end
         ALLOCATE: begin
            if (mem_ack_i) begin
               fill_en           = 1'b1;
               valid_d[miss_idx] = 1'b1;
               dirty_d[miss_idx] = 1'b0;
               mem_req_d         = 1'b0;
               mem_we_d          = 1'b0;
               state_d           = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Control and memory-interface registers; reset drops any open transaction at once.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q     <= IDLE;
         valid_q     <= '0;
         dirty_q     <= '0;
         miss_line_q <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         valid_q     <= valid_d;
         dirty_q     <= dirty_d;
         miss_line_q <= miss_line_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   // Tag/data array writes: whole-line install on fill ack, single-word merge on store hit.
   always_ff @(posedge clk_i) begin
      if (fill_en) begin
         data_arr_q[miss_idx] <= mem_rdata_i;
         tag_arr_q[miss_idx]  <= miss_tag;
      end else if (store_en) begin
         data_arr_q[cpu_idx][{cpu_word, 5'b0} +: 32] <= cpu_wdata_i;
      end
   end

endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller. The reference is an architectural memory view
// (every load returns the latest value stored to that address) plus a table of
// which line each index holds and whether it was written, from which the expected
// memory transactions and stall lengths follow. A slow-memory responder answers
// transactions with bench-chosen latencies and checks them against a queue.
module tb_dcache_controller;

   logic         clk_i = 1'b0;
   logic         rst_i;
   logic         cpu_req_i;
   logic         cpu_we_i;
   logic [31:0]  cpu_addr_i;
   logic [31:0]  cpu_wdata_i;
   logic [31:0]  cpu_rdata_o;
   logic         cpu_stall_o;
   logic         mem_req_o;
   logic         mem_we_o;
   logic [31:0]  mem_addr_o;
   logic [255:0] mem_wdata_o;
   logic [255:0] mem_rdata_i;
   logic         mem_ack_i;

   // ---------------- clock / reset ----------------
   always #5 clk_i = ~clk_i;

   dcache_controller dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .cpu_req_i   (cpu_req_i),
      .cpu_we_i    (cpu_we_i),
      .cpu_addr_i  (cpu_addr_i),
      .cpu_wdata_i (cpu_wdata_i),
      .cpu_rdata_o (cpu_rdata_o),
      .cpu_stall_o (cpu_stall_o),
      .mem_req_o   (mem_req_o),
      .mem_we_o    (mem_we_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_rdata_i (mem_rdata_i),
      .mem_ack_i   (mem_ack_i)
   );

   // ---------------- scoreboard state ----------------
   typedef struct {
      logic         we;
      logic [31:0]  addr;
      logic [255:0] data;
   } txn_t;

   logic [31:0] exp_q[$];        // expected load data, in order
   txn_t        mem_exp_q[$];    // expected memory transactions, in order
   int          lat_q[$];        // latency to use for each expected transaction

   int n_checks = 0;
   int n_pass   = 0;
   int spur_cnt = 0;
   int spur_done = 0;
   bit resp_busy = 1'b0;

   // Reference: architectural memory and backing memory (absent words = init pattern)
   logic [31:0] ref_mem [logic [31:0]];
   logic [31:0] bk_mem  [logic [31:0]];
   logic [26:0] res_line  [32];
   bit          res_valid [32];
   bit          res_dirty [32];

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      $display("FAIL %s: event occurred but none expected", name);
   endtask

   task automatic report_and_finish();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   endtask

   function automatic logic [31:0] init_word(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
   endfunction

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
   endfunction

   function automatic logic [31:0] bk_rd(input logic [31:0] a);
      return bk_mem.exists(a) ? bk_mem[a] : init_word(a);
   endfunction

   function automatic logic [255:0] ref_line(input logic [26:0] ln);
      logic [255:0] l;
      logic [2:0]   wv;
      for (int w = 0; w < 8; w++) begin
         wv = 3'(w);
         l[w*32 +: 32] = ref_rd({ln, wv, 2'b00});
      end
      return l;
   endfunction

   // Update the reference for one access and queue what the DUT must do.
   task automatic model_access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                               input int lwb, input int lfill, input bit want_read,
                               output int exp_stall);
      logic [4:0]  idx;
      logic [26:0] ln;
      txn_t        t;
      idx = a[9:5];
      ln  = a[31:5];
      exp_stall = 0;
      if (!(res_valid[idx] && res_line[idx] == ln)) begin
         if (res_valid[idx] && res_dirty[idx]) begin
            t.we = 1'b1; t.addr = {res_line[idx], 5'b0}; t.data = ref_line(res_line[idx]);
            mem_exp_q.push_back(t);
            lat_q.push_back(lwb);
            exp_stall += lwb;
         end
         t.we = 1'b0; t.addr = {ln, 5'b0}; t.data = '0;
         mem_exp_q.push_back(t);
         lat_q.push_back(lfill);
         exp_stall += lfill + 1;
         res_valid[idx] = 1'b1;
         res_line[idx]  = ln;
         res_dirty[idx] = 1'b0;
      end
      if (we) begin
         ref_mem[a]     = wd;
         res_dirty[idx] = 1'b1;
      end else if (want_read) begin
         exp_q.push_back(ref_rd(a));
      end
   endtask

   // ---------------- driver ----------------
   // Called just after a rising edge; returns just after a rising edge with cpu_req_i low.
   task automatic access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input int lwb, input int lfill);
      int  es;
      int  cnt;
      bit  done;
      model_access(we, a, wd, lwb, lfill, 1'b1, es);
      cpu_req_i   = 1'b1;
      cpu_we_i    = we;
      cpu_addr_i  = a;
      cpu_wdata_i = wd;
      cnt  = 0;
      done = 1'b0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk_i);
         if (!cpu_stall_o) begin
            done = 1'b1;
            break;
         end
         cnt++;
      end
      if (!done) begin
         $display("FAIL access_timeout: stall still high after %0d cycles at addr %0h", cnt, a);
         n_checks++;
         report_and_finish();
      end
      chk("stall_cycles", cnt, es);
      @(posedge clk_i);
      #1;
      cpu_req_i = 1'b0;
   endtask

   task automatic wait_mem_quiet();
      bit done;
      done = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk_i);
         if (mem_exp_q.size() == 0 && !mem_req_o && !resp_busy) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) begin
         $display("FAIL mem_quiet_timeout: transactions still pending %0d", mem_exp_q.size());
         n_checks++;
         report_and_finish();
      end
      @(posedge clk_i);
      #1;
   endtask

   // ---------------- monitor: load data ----------------
   always @(negedge clk_i) begin
      if (rst_i && cpu_req_i && !cpu_stall_o && !cpu_we_i) begin
         if (exp_q.size() == 0) fail_now("unexpected_load");
         else chk("load_rdata", cpu_rdata_o, exp_q.pop_front());
      end
   end

   // ---------------- slow memory responder / transaction monitor ----------------
   initial begin
      txn_t cur;
      int   lat;
      int   cnt;
      bit   unexp;
      logic [255:0] line;
      logic [2:0]   wv;
      mem_ack_i   = 1'b0;
      mem_rdata_i = '0;
      lat = 1; cnt = 0; unexp = 1'b0;
      forever begin
         @(negedge clk_i);
         if (!rst_i) begin
            resp_busy = 1'b0;
            mem_ack_i = 1'b0;
            continue;
         end
         if (mem_ack_i) begin
            mem_ack_i = 1'b0;
            resp_busy = 1'b0;
         end
         if (!resp_busy && mem_req_o) begin
            if (mem_exp_q.size() == 0 || lat_q.size() == 0) begin
               fail_now("unexpected_mem_txn");
               cur.we = mem_we_o; cur.addr = mem_addr_o; cur.data = mem_wdata_o;
               lat = 1;
               unexp = 1'b1;
            end else begin
               cur = mem_exp_q.pop_front();
               lat = lat_q.pop_front();
               unexp = 1'b0;
               chk("txn_we", mem_we_o, cur.we);
               chk("txn_addr", mem_addr_o, cur.addr);
               if (cur.we) chk("txn_wdata", mem_wdata_o, cur.data);
            end
            resp_busy = 1'b1;
            cnt = 0;
         end
         if (resp_busy) begin
            cnt++;
            if (cnt == lat) begin
               if (!unexp) begin
                  chk("txn_hold_req", mem_req_o, 1'b1);
                  chk("txn_hold_addr", mem_addr_o, cur.addr);
                  chk("txn_hold_we", mem_we_o, cur.we);
               end
               if (cur.we) begin
                  for (int w = 0; w < 8; w++) begin
                     wv = 3'(w);
                     bk_mem[{cur.addr[31:5], wv, 2'b00}] = mem_wdata_o[w*32 +: 32];
                  end
               end else begin
                  for (int w = 0; w < 8; w++) begin
                     wv = 3'(w);
                     line[w*32 +: 32] = bk_rd({cur.addr[31:5], wv, 2'b00});
                  end
                  mem_rdata_i = line;
               end
               mem_ack_i = 1'b1;
            end
         end else if (spur_done < spur_cnt && !mem_req_o) begin
            mem_ack_i = 1'b1;
            spur_done++;
         end
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      n_checks++;
      report_and_finish();
   end

   // ---------------- main stimulus ----------------
   initial begin
      int es;
      logic [31:0] a;
      rst_i       = 1'b0;
      cpu_req_i   = 1'b0;
      cpu_we_i    = 1'b0;
      cpu_addr_i  = '0;
      cpu_wdata_i = '0;
      for (int i = 0; i < 32; i++) begin
         res_valid[i] = 1'b0;
         res_dirty[i] = 1'b0;
         res_line[i]  = '0;
      end
      bk_mem[32'h48]  = 32'hDEAD_BEEF;
      ref_mem[32'h48] = 32'hDEAD_BEEF;

      repeat (3) @(negedge clk_i);
      #3 rst_i = 1'b1;
      @(negedge clk_i);
      chk("rst_stall", cpu_stall_o, 1'b0);
      chk("rst_mem_req", mem_req_o, 1'b0);
      chk("rst_mem_we", mem_we_o, 1'b0);
      chk("rst_mem_addr", mem_addr_o, 32'h0);
      chk("rst_mem_wdata", mem_wdata_o, 256'h0);
      @(posedge clk_i);
      #1;

      // Clean miss with 3-cycle fill: 4 stall cycles, word2 = DEADBEEF
      access(1'b0, 32'h0000_0040, 32'h0, 1, 3);
      access(1'b0, 32'h0000_0048, 32'h0, 1, 1);
      chk("seed_word_visible", ref_rd(32'h48), 32'hDEAD_BEEF);
      // Hit load, store hit, load-after-store
      access(1'b0, 32'h0000_0044, 32'h0, 1, 1);
      access(1'b1, 32'h0000_0048, 32'h1234_5678, 1, 1);
      access(1'b0, 32'h0000_0048, 32'h0, 1, 1);
      // Conflict on index 2 with a dirty victim: write-back to 0x40 then fill 0x440
      access(1'b0, 32'h0000_0448, 32'h0, 2, 3);
      // Store miss to a clean/invalid line, then read it, then evict it
      access(1'b1, 32'h0000_0880, 32'hCAFE_0880, 1, 2);
      access(1'b0, 32'h0000_0880, 32'h0, 1, 1);
      access(1'b0, 32'h0000_1080, 32'h0, 3, 2);
      // Ack in the first request cycle, for both write-back and fill
      access(1'b1, 32'h0000_00C0, 32'h0BAD_F00D, 1, 1);
      access(1'b0, 32'h0000_10C0, 32'h0, 1, 1);

      // Ack while idle must be ignored
      spur_cnt++;
      repeat (2) @(negedge clk_i);
      chk("spurious_ack_no_req", mem_req_o, 1'b0);
      @(posedge clk_i);
      #1;
      access(1'b0, 32'h0000_00C4, 32'h0, 1, 2);

      // Request dropped mid-miss: the line still installs and then hits
      model_access(1'b0, 32'h0000_3000, 32'h0, 2, 3, 1'b0, es);
      cpu_req_i  = 1'b1;
      cpu_we_i   = 1'b0;
      cpu_addr_i = 32'h0000_3000;
      @(negedge clk_i);
      chk("flush_stall_high", cpu_stall_o, 1'b1);
      @(posedge clk_i);
      #1;
      cpu_req_i = 1'b0;
      wait_mem_quiet();
      access(1'b0, 32'h0000_3004, 32'h0, 1, 1);

      // Reset during a fill: request drops immediately, line is not installed
      a = 32'h0000_2000;
      model_access(1'b0, a, 32'h0, 1, 20, 1'b1, es);
      cpu_req_i  = 1'b1;
      cpu_we_i   = 1'b0;
      cpu_addr_i = a;
      repeat (4) @(negedge clk_i);
      chk("pre_reset_req", mem_req_o, 1'b1);
      #3;
      rst_i     = 1'b0;
      cpu_req_i = 1'b0;
      #1;
      chk("async_rst_req", mem_req_o, 1'b0);
      chk("async_rst_addr", mem_addr_o, 32'h0);
      exp_q.delete();
      mem_exp_q.delete();
      lat_q.delete();
      for (int i = 0; i < 32; i++) begin
         res_valid[i] = 1'b0;
         res_dirty[i] = 1'b0;
      end
      ref_mem.delete();
      foreach (bk_mem[k]) ref_mem[k] = bk_mem[k];
      repeat (2) @(negedge clk_i);
      #3 rst_i = 1'b1;
      @(negedge clk_i);
      chk("stall_idle_after_rst", cpu_stall_o, 1'b0);
      chk("req_idle_after_rst", mem_req_o, 1'b0);
      @(posedge clk_i);
      #1;
      access(1'b0, a, 32'h0, 1, 2);

      // Randomized traffic over a few conflicting indices and tags
      for (int n = 0; n < 250; n++) begin
         logic [21:0] tg;
         logic [4:0]  ix;
         logic [2:0]  wd;
         tg = 22'($urandom_range(0, 3));
         ix = 5'($urandom_range(0, 3));
         wd = 3'($urandom_range(0, 7));
         a  = {tg, ix, wd, 2'b00};
         if ($urandom_range(0, 9) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk_i);
            #1;
         end
         access(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(1, 4), $urandom_range(1, 4));
      end

      wait_mem_quiet();
      chk("load_queue_drained", exp_q.size(), 0);
      chk("mem_queue_drained", mem_exp_q.size(), 0);
      report_and_finish();
   end

endmodule
